// File: rtl/control_multiciclo.sv
// Multi-cycle control FSM for the RV32I datapath: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and muxes, counts retired instructions and traps on illegal opcodes or memory timeouts.
module control_multiciclo #(
    parameter int unsigned MAX_ESPERA = 15,
    parameter int unsigned ANCHO_CONT = 32
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [6:0]            opcode,
    input  logic                  mem_listo,
    input  logic                  salto_tomado,
    output logic [2:0]            tipo,
    output logic                  ir_escribe,
    output logic                  pc_escribe,
    output logic                  sel_pc,
    output logic                  mem_lee,
    output logic                  mem_escribe,
    output logic                  sel_dir,
    output logic                  reg_escribe,
    output logic [1:0]            sel_resultado,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b,
    output logic [1:0]            op_alu,
    output logic                  error,
    output logic [ANCHO_CONT-1:0] retiradas
);

    localparam int unsigned ANCHO_ESPERA = 8;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] TIPO_I = 3'b000;
    localparam logic [2:0] TIPO_S = 3'b001;
    localparam logic [2:0] TIPO_B = 3'b010;
    localparam logic [2:0] TIPO_U = 3'b011;
    localparam logic [2:0] TIPO_J = 3'b100;

    localparam logic [1:0] A_RS1  = 2'b00;
    localparam logic [1:0] A_PC   = 2'b01;
    localparam logic [1:0] A_CERO = 2'b10;
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_FUNCT = 2'b01;
    localparam logic [1:0] ALU_SALTO = 2'b10;
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [ANCHO_ESPERA-1:0] LIMITE_ESPERA = ANCHO_ESPERA'(MAX_ESPERA);

    typedef enum logic [2:0] {
        INICIO,
        BUSCA,
        DECODIFICA,
        EJECUTA,
        MEMORIA,
        ESCRIBE,
        ERROR
    } estado_t;

    typedef enum logic [3:0] {
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_OPIMM,
        C_OP,
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR,
        C_ILEGAL
    } clase_t;

    estado_t                 estado, estado_sig;
    clase_t                  clase;
    logic [ANCHO_ESPERA-1:0] espera, espera_sig;
    logic [2:0]              tipo_op;

    // Instruction class and immediate format from the opcode
    always_comb begin
        clase   = C_ILEGAL;
        tipo_op = TIPO_I;
        case (opcode)
            OPC_LOAD:   clase = C_LOAD;
            OPC_STORE:  begin clase = C_STORE;  tipo_op = TIPO_S; end
            OPC_BRANCH: begin clase = C_BRANCH; tipo_op = TIPO_B; end
            OPC_OPIMM:  clase = C_OPIMM;
            OPC_OP:     clase = C_OP;
            OPC_LUI:    begin clase = C_LUI;    tipo_op = TIPO_U; end
            OPC_AUIPC:  begin clase = C_AUIPC;  tipo_op = TIPO_U; end
            OPC_JAL:    begin clase = C_JAL;    tipo_op = TIPO_J; end
            OPC_JALR:   clase = C_JALR;
            default:    clase = C_ILEGAL;
        endcase
    end

    // State, wait counter, sticky error and retire counter
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            estado    <= INICIO;
            espera    <= '0;
            error     <= 1'b0;
            retiradas <= '0;
        end else begin
            estado <= estado_sig;
            espera <= espera_sig;
            error  <= error | (estado_sig == ERROR);
            if (pc_escribe) begin
                retiradas <= retiradas + ANCHO_CONT'(1);
            end
        end
    end

    // Next state and Moore/Mealy datapath controls
    always_comb begin
        estado_sig    = estado;
        espera_sig    = '0;
        tipo          = TIPO_I;
        ir_escribe    = 1'b0;
        pc_escribe    = 1'b0;
        sel_pc        = 1'b0;
        mem_lee       = 1'b0;
        mem_escribe   = 1'b0;
        sel_dir       = 1'b0;
        reg_escribe   = 1'b0;
        sel_resultado = RES_ALU;
        sel_a         = A_RS1;
        sel_b         = B_RS2;
        op_alu        = ALU_ADD;

        if (estado != INICIO && estado != ERROR) begin
            tipo = tipo_op;
        end

        case (estado)
            INICIO: begin
                estado_sig = BUSCA;
            end

            BUSCA: begin
                mem_lee = 1'b1;
                if (mem_listo) begin
                    ir_escribe = 1'b1;
                    estado_sig = DECODIFICA;
                end else if (espera >= LIMITE_ESPERA) begin
                    estado_sig = ERROR;
                end else begin
                    espera_sig = espera + ANCHO_ESPERA'(1);
                end
            end

            DECODIFICA: begin
                sel_a  = A_PC;
                sel_b  = B_IMM;
                op_alu = ALU_ADD;
                estado_sig = (clase == C_ILEGAL) ? ERROR : EJECUTA;
            end

            EJECUTA: begin
                estado_sig = ESCRIBE;
                case (clase)
                    C_OP: begin
                        op_alu = ALU_FUNCT;
                    end
                    C_OPIMM: begin
                        sel_b  = B_IMM;
                        op_alu = ALU_FUNCT;
                    end
                    C_LOAD, C_STORE: begin
                        sel_b      = B_IMM;
                        estado_sig = MEMORIA;
                    end
                    C_JALR: begin
                        sel_b = B_IMM;
                    end
                    C_LUI: begin
                        sel_a = A_CERO;
                        sel_b = B_IMM;
                    end
                    C_AUIPC, C_JAL: begin
                        sel_a = A_PC;
                        sel_b = B_IMM;
                    end
                    C_BRANCH: begin
                        op_alu     = ALU_SALTO;
                        pc_escribe = 1'b1;
                        sel_pc     = salto_tomado;
                        estado_sig = BUSCA;
                    end
                    default: begin
                        estado_sig = ERROR;
                    end
                endcase
            end

            MEMORIA: begin
                sel_dir     = 1'b1;
                mem_lee     = (clase == C_LOAD);
                mem_escribe = (clase == C_STORE);
                if (mem_listo) begin
                    if (clase == C_LOAD) begin
                        estado_sig = ESCRIBE;
                    end else if (clase == C_STORE) begin
                        pc_escribe = 1'b1;
                        estado_sig = BUSCA;
                    end else begin
                        estado_sig = ERROR;
                    end
                end else if (espera >= LIMITE_ESPERA) begin
                    estado_sig = ERROR;
                end else begin
                    espera_sig = espera + ANCHO_ESPERA'(1);
                end
            end

            ESCRIBE: begin
                reg_escribe = 1'b1;
                pc_escribe  = 1'b1;
                estado_sig  = BUSCA;
                if (clase == C_LOAD) begin
                    sel_resultado = RES_MEM;
                end else if (clase == C_JAL || clase == C_JALR) begin
                    sel_resultado = RES_PC4;
                    sel_pc        = 1'b1;
                end
            end

            ERROR: begin
                estado_sig = ERROR;
            end

            default: begin
                estado_sig = ERROR;
            end
        endcase
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-cycle expected control vectors are queued and
// checked against the DUT on the falling edge.
module tb_control_multiciclo;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ADDI   = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    logic        clk = 1'b0;
    logic        nreset;
    logic [6:0]  opcode;
    logic        mem_listo;
    logic        salto_tomado;
    logic [2:0]  tipo;
    logic        ir_escribe, pc_escribe, sel_pc, mem_lee, mem_escribe, sel_dir, reg_escribe;
    logic [1:0]  sel_resultado, sel_a, sel_b, op_alu;
    logic        error;
    logic [31:0] retiradas;

    control_multiciclo #(.MAX_ESPERA(15), .ANCHO_CONT(32)) dut (
        .clk(clk), .nreset(nreset), .opcode(opcode), .mem_listo(mem_listo),
        .salto_tomado(salto_tomado), .tipo(tipo), .ir_escribe(ir_escribe),
        .pc_escribe(pc_escribe), .sel_pc(sel_pc), .mem_lee(mem_lee),
        .mem_escribe(mem_escribe), .sel_dir(sel_dir), .reg_escribe(reg_escribe),
        .sel_resultado(sel_resultado), .sel_a(sel_a), .sel_b(sel_b), .op_alu(op_alu),
        .error(error), .retiradas(retiradas)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {tipo, ir_escribe, pc_escribe, sel_pc, mem_lee, mem_escribe, sel_dir,
                  reg_escribe, sel_resultado, sel_a, sel_b, op_alu, error};

    typedef struct {
        string       tag;
        logic [18:0] vec;
        logic [31:0] ret;
    } esperado_t;

    esperado_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    // Fields: tipo, ir, pc_w, sel_pc, lee, escribe, sel_dir, reg_w, sel_res, sel_a, sel_b, op_alu, error
    function automatic logic [18:0] ev(input logic [2:0] t, input logic ir, input logic pcw,
                                       input logic spc, input logic lee, input logic esc,
                                       input logic dir, input logic rg, input logic [1:0] sres,
                                       input logic [1:0] sa, input logic [1:0] sbb,
                                       input logic [1:0] op, input logic err);
        return {t, ir, pcw, spc, lee, esc, dir, rg, sres, sa, sbb, op, err};
    endfunction

    task automatic step(input string tag, input logic [18:0] v, input logic [31:0] r);
        esperado_t e;
        e.tag = tag;
        e.vec = v;
        e.ret = r;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            assert (obs === e.vec) else begin
                n_err++;
                $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs, e.vec);
            end
            n_vec++;
            assert (retiradas === e.ret) else begin
                n_err++;
                $error("FAIL %s retiradas: observed %0d expected %0d", e.tag, retiradas, e.ret);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic skip_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [18:0] v_zero, v_err, v_dec;

    initial begin
        v_zero = '0;
        v_err  = ev(3'b000, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        v_dec  = ev(3'b000, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
        nreset = 1'b0;
        opcode = OPC_ADDI;
        mem_listo = 1'b1;
        salto_tomado = 1'b0;
        @(posedge clk);
        #1;

        // ADDI through the full path
        step("rst", v_zero, 0);
        nreset = 1'b1;
        step("addi_ini", v_zero, 0);
        step("addi_bus", ev(3'b000, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        step("addi_dec", v_dec, 0);
        step("addi_eje", ev(3'b000, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b01, 0), 0);
        step("addi_esc", ev(3'b000, 0,1,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);

        // Branch taken then not taken
        opcode = OPC_BRANCH;
        salto_tomado = 1'b1;
        step("beq1_bus", ev(3'b010, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
        step("beq1_dec", ev(3'b010, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 1);
        step("beq1_eje", ev(3'b010, 0,1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b10, 0), 1);
        salto_tomado = 1'b0;
        step("beq0_bus", ev(3'b010, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 2);
        step("beq0_dec", ev(3'b010, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 2);
        step("beq0_eje", ev(3'b010, 0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b10, 0), 2);

        // Load with memory ready delayed three cycles
        opcode = OPC_LOAD;
        step("lw_bus", ev(3'b000, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 3);
        step("lw_dec", v_dec, 3);
        step("lw_eje", ev(3'b000, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0), 3);
        mem_listo = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("lw_mem_wait", ev(3'b000, 0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 3);
        end
        mem_listo = 1'b1;
        step("lw_mem_ok", ev(3'b000, 0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 3);
        step("lw_esc", ev(3'b000, 0,1,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 0), 3);

        // JAL
        opcode = OPC_JAL;
        step("jal_bus", ev(3'b100, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 4);
        step("jal_dec", ev(3'b100, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 4);
        step("jal_eje", ev(3'b100, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 4);
        step("jal_esc", ev(3'b100, 0,1,1,0,0,0,1, 2'b10, 2'b00, 2'b00, 2'b00, 0), 4);

        // STORE
        opcode = OPC_STORE;
        step("sw_bus", ev(3'b001, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 5);
        step("sw_dec", ev(3'b001, 0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0), 5);
        step("sw_eje", ev(3'b001, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0), 5);
        step("sw_mem", ev(3'b001, 0,1,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 5);

        // Fetch timeout: memory never ready
        mem_listo = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step("to_bus", ev(3'b001, 0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 6);
        end
        skip_cycle();
        step("to_err", v_err, 6);
        mem_listo = 1'b1;
        step("to_sticky1", v_err, 6);
        step("to_sticky2", v_err, 6);

        // Reset clears the trap; illegal opcode traps from decode
        nreset = 1'b0;
        step("rst2", v_zero, 0);
        nreset = 1'b1;
        opcode = OPC_BAD;
        step("bad_ini", v_zero, 0);
        step("bad_bus", ev(3'b000, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        step("bad_dec", v_dec, 0);
        step("bad_err1", v_err, 0);
        step("bad_err2", v_err, 0);

        // Reset during the memory phase of a load
        nreset = 1'b0;
        step("rst3", v_zero, 0);
        nreset = 1'b1;
        opcode = OPC_LOAD;
        step("rl_ini", v_zero, 0);
        step("rl_bus", ev(3'b000, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        step("rl_dec", v_dec, 0);
        step("rl_eje", ev(3'b000, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0), 0);
        step("rl_mem", ev(3'b000, 0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        step("rl_esc", ev(3'b000, 0,1,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 0), 0);
        step("rl2_bus", ev(3'b000, 1,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
        step("rl2_dec", v_dec, 1);
        step("rl2_eje", ev(3'b000, 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b01, 2'b00, 0), 1);
        mem_listo = 1'b0;
        step("rl2_mem", ev(3'b000, 0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
        nreset = 1'b0;
        step("rst_mid", v_zero, 0);
        nreset = 1'b1;
        step("rm_ini", v_zero, 0);
        for (int i = 0; i < 3; i++) begin
            step("rm_bus", ev(3'b000, 0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
